// File: rtl/video_pkg.sv
// rtl/video_pkg.sv - shared 800x600 video timing constants and coordinate type
// Purpose: single source of the display timing used by the timing
//          controller, background and sprite blocks.
// Contents: H_*/V_* porch/sync/active sizes, derived H_BLK/H_TOT/V_BLK/V_TOT,
//           coord_t (11-bit signed scan coordinate).
package video_pkg;

    localparam int H_ACTIVE = 800;
    localparam int H_FP     = 56;
    localparam int H_SYNC   = 120;
    localparam int H_BP     = 64;
    localparam int V_ACTIVE = 600;
    localparam int V_FP     = 37;
    localparam int V_SYNC   = 6;
    localparam int V_BP     = 23;

    localparam int H_BLK = H_FP + H_SYNC + H_BP;
    localparam int H_TOT = H_BLK + H_ACTIVE;
    localparam int V_BLK = V_FP + V_SYNC + V_BP;
    localparam int V_TOT = V_BLK + V_ACTIVE;

    // Blanking sits at negative coordinates so active video starts at 0.
    typedef logic signed [10:0] coord_t;

endpackage

// File: rtl/sync_delay.sv
// rtl/sync_delay.sv - enabled shift register with a fixed reset value
// Purpose: delays a small bundle of control bits by DEPTH enabled cycles.
// Ports:
//   clk, reset  clock and asynchronous active-high reset
//   en          shift enable; contents hold while low
//   din         bits entering the first stage
//   dout        bits leaving the last stage
module sync_delay #(
    parameter int                WIDTH     = 3,
    parameter int                DEPTH     = 1,
    parameter logic [WIDTH-1:0]  RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    logic [WIDTH-1:0] stage_q [DEPTH];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                stage_q[i] <= RESET_VAL;
            end
        end else if (en) begin
            stage_q[0] <= din;
            for (int i = 1; i < DEPTH; i++) begin
                stage_q[i] <= stage_q[i-1];
            end
        end
    end

    assign dout = stage_q[DEPTH-1];

endmodule

// File: rtl/vga_timing_ctrl.sv
// rtl/vga_timing_ctrl.sv - master scan sequencer: spot coordinates, syncs, strobes
// Purpose: walks the raster one pixel per enabled clock, producing signed
//          coordinates, pipeline-aligned hsync/vsync/blank and line/frame strobes.
// Ports:
//   clk, reset      pixel clock, asynchronous active-high reset
//   pix_en          pixel advance enable; everything holds while low
//   spotX, spotY    signed scan position, 0.. during active video
//   hsync, vsync    active-high syncs, delayed PIPE_DELAY enabled cycles
//   blank           high outside the active area, delayed PIPE_DELAY
//   line_start      pulse on the first pixel of every line (enabled cycles only)
//   frame_start     pulse on the first pixel of every frame
//   frame_cnt       frames completed, modulo 256
module vga_timing_ctrl #(
    parameter int H_ACTIVE   = video_pkg::H_ACTIVE,
    parameter int H_FP       = video_pkg::H_FP,
    parameter int H_SYNC     = video_pkg::H_SYNC,
    parameter int H_BP       = video_pkg::H_BP,
    parameter int V_ACTIVE   = video_pkg::V_ACTIVE,
    parameter int V_FP       = video_pkg::V_FP,
    parameter int V_SYNC     = video_pkg::V_SYNC,
    parameter int V_BP       = video_pkg::V_BP,
    parameter int PIPE_DELAY = 1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                pix_en,
    output logic signed [10:0]  spotX,
    output logic signed [10:0]  spotY,
    output logic                hsync,
    output logic                vsync,
    output logic                blank,
    output logic                line_start,
    output logic                frame_start,
    output logic [7:0]          frame_cnt
);

    localparam int H_BLK = H_FP + H_SYNC + H_BP;
    localparam int V_BLK = V_FP + V_SYNC + V_BP;

    // Coordinates are counted directly in the signed domain; hcnt/vcnt are
    // implied as spot + blanking width.
    localparam video_pkg::coord_t X_FIRST = video_pkg::coord_t'(-H_BLK);
    localparam video_pkg::coord_t X_LAST  = video_pkg::coord_t'(H_ACTIVE - 1);
    localparam video_pkg::coord_t Y_FIRST = video_pkg::coord_t'(-V_BLK);
    localparam video_pkg::coord_t Y_LAST  = video_pkg::coord_t'(V_ACTIVE - 1);
    localparam video_pkg::coord_t HS_ON   = video_pkg::coord_t'(H_FP - H_BLK);
    localparam video_pkg::coord_t HS_OFF  = video_pkg::coord_t'(H_FP + H_SYNC - H_BLK);
    localparam video_pkg::coord_t VS_ON   = video_pkg::coord_t'(V_FP - V_BLK);
    localparam video_pkg::coord_t VS_OFF  = video_pkg::coord_t'(V_FP + V_SYNC - V_BLK);

    video_pkg::coord_t x_q, y_q, x_d, y_d;
    logic [7:0]        fc_q, fc_d;
    logic [2:0]        raw_d;
    logic [2:0]        sync_out;

    always_comb begin
        x_d  = x_q + 11'sd1;
        y_d  = y_q;
        fc_d = fc_q;
        if (x_q == X_LAST) begin
            x_d = X_FIRST;
            if (y_q == Y_LAST) begin
                y_d  = Y_FIRST;
                fc_d = fc_q + 8'd1;
            end else begin
                y_d = y_q + 11'sd1;
            end
        end
    end

    // Raw timing is decoded from the next position so that, once registered,
    // it lines up with spotX; extra stages then add PIPE_DELAY on top.
    always_comb begin
        raw_d    = 3'b000;
        raw_d[2] = (x_d >= HS_ON) && (x_d < HS_OFF);
        raw_d[1] = (y_d >= VS_ON) && (y_d < VS_OFF);
        raw_d[0] = (x_d < 11'sd0) || (y_d < 11'sd0);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            x_q  <= X_FIRST;
            y_q  <= Y_FIRST;
            fc_q <= 8'd0;
        end else if (pix_en) begin
            x_q  <= x_d;
            y_q  <= y_d;
            fc_q <= fc_d;
        end
    end

    sync_delay #(
        .WIDTH     (3),
        .DEPTH     (PIPE_DELAY + 1),
        .RESET_VAL (3'b001)
    ) u_sync_delay (
        .clk   (clk),
        .reset (reset),
        .en    (pix_en),
        .din   (raw_d),
        .dout  (sync_out)
    );

    assign spotX     = x_q;
    assign spotY     = y_q;
    assign hsync     = sync_out[2];
    assign vsync     = sync_out[1];
    assign blank     = sync_out[0];
    assign frame_cnt = fc_q;

    // Strobes mark the enabled cycle that sits on the first pixel, so they are
    // qualified by the live pix_en and masked while reset is held.
    assign line_start  = pix_en && !reset && (x_q == X_FIRST);
    assign frame_start = line_start && (y_q == Y_FIRST);

endmodule

// File: tb/tb_vga_timing_ctrl.sv
// tb/tb_vga_timing_ctrl.sv - self-checking bench for vga_timing_ctrl
module tb_vga_timing_ctrl;

    localparam int NI = 4;
    localparam int P_HA [NI] = '{8, 8, 8, 800};
    localparam int P_HF [NI] = '{2, 2, 2, 56};
    localparam int P_HS [NI] = '{3, 3, 3, 120};
    localparam int P_HB [NI] = '{2, 2, 2, 64};
    localparam int P_VA [NI] = '{4, 4, 4, 600};
    localparam int P_VF [NI] = '{1, 1, 1, 37};
    localparam int P_VS [NI] = '{2, 2, 2, 6};
    localparam int P_VB [NI] = '{1, 1, 1, 23};
    localparam int P_D  [NI] = '{1, 0, 3, 1};

    logic clk = 1'b0;
    logic reset;
    logic pix_en;

    logic signed [10:0] sx [NI];
    logic signed [10:0] sy [NI];
    logic               hs [NI];
    logic               vs [NI];
    logic               bl [NI];
    logic               ls [NI];
    logic               fs [NI];
    logic [7:0]         fc [NI];

    int     n_assert = 0;
    int     n_fail   = 0;
    longint n        = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < NI; g++) begin : g_dut
        vga_timing_ctrl #(
            .H_ACTIVE   (P_HA[g]),
            .H_FP       (P_HF[g]),
            .H_SYNC     (P_HS[g]),
            .H_BP       (P_HB[g]),
            .V_ACTIVE   (P_VA[g]),
            .V_FP       (P_VF[g]),
            .V_SYNC     (P_VS[g]),
            .V_BP       (P_VB[g]),
            .PIPE_DELAY (P_D[g])
        ) u_dut (
            .clk         (clk),
            .reset       (reset),
            .pix_en      (pix_en),
            .spotX       (sx[g]),
            .spotY       (sy[g]),
            .hsync       (hs[g]),
            .vsync       (vs[g]),
            .blank       (bl[g]),
            .line_start  (ls[g]),
            .frame_start (fs[g]),
            .frame_cnt   (fc[g])
        );
    end

    task automatic chk(input string tag, input int k,
                       input logic signed [31:0] obs, input logic signed [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s inst%0d: observed %0d expected %0d (step %0d)", tag, k, obs, exp, n);
        end
    endtask

    // Reference: position after n enabled steps is plain division of n by the
    // line and frame lengths; delayed syncs are the raw rule evaluated n-D steps ago.
    task automatic check_all();
        for (int k = 0; k < NI; k++) begin
            int     hblk, vblk, htot, vtot, hc, vc, mh, mv, e_fc;
            longint m;
            logic   e_hs, e_vs, e_bl, e_ls, e_fs;
            hblk = P_HF[k] + P_HS[k] + P_HB[k];
            vblk = P_VF[k] + P_VS[k] + P_VB[k];
            htot = hblk + P_HA[k];
            vtot = vblk + P_VA[k];
            hc   = int'(n % htot);
            vc   = int'((n / htot) % vtot);
            e_fc = int'((n / (htot * vtot)) % 256);
            e_ls = pix_en && (hc == 0);
            e_fs = e_ls && (vc == 0);
            m    = n - P_D[k];
            if (m < 0) begin
                e_hs = 1'b0; e_vs = 1'b0; e_bl = 1'b1;
            end else begin
                mh   = int'(m % htot);
                mv   = int'((m / htot) % vtot);
                e_hs = (mh >= P_HF[k]) && (mh < P_HF[k] + P_HS[k]);
                e_vs = (mv >= P_VF[k]) && (mv < P_VF[k] + P_VS[k]);
                e_bl = (mh < hblk) || (mv < vblk);
            end
            chk("spotX", k, sx[k], hc - hblk);
            chk("spotY", k, sy[k], vc - vblk);
            chk("hsync", k, hs[k], e_hs);
            chk("vsync", k, vs[k], e_vs);
            chk("blank", k, bl[k], e_bl);
            chk("line_start", k, ls[k], e_ls);
            chk("frame_start", k, fs[k], e_fs);
            chk("frame_cnt", k, fc[k], e_fc);
        end
    endtask

    task automatic check_reset();
        for (int k = 0; k < NI; k++) begin
            chk("rst_spotX", k, sx[k], -(P_HF[k] + P_HS[k] + P_HB[k]));
            chk("rst_spotY", k, sy[k], -(P_VF[k] + P_VS[k] + P_VB[k]));
            chk("rst_hsync", k, hs[k], 0);
            chk("rst_vsync", k, vs[k], 0);
            chk("rst_blank", k, bl[k], 1);
            chk("rst_line_start", k, ls[k], 0);
            chk("rst_frame_start", k, fs[k], 0);
            chk("rst_frame_cnt", k, fc[k], 0);
        end
    endtask

    task automatic run(input int cycles, input bit random_en);
        for (int c = 0; c < cycles; c++) begin
            @(negedge clk);
            check_all();
            @(posedge clk);
            if (pix_en) n++;
            #1;
            pix_en = random_en ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    endtask

    task automatic release_reset();
        @(posedge clk);
        #1;
        reset  = 1'b0;
        pix_en = 1'b1;
        n      = 0;
    endtask

    initial begin
        reset  = 1'b1;
        pix_en = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check_reset();

        // 258 short frames: exercises frame_cnt wrap 255->0 on the short
        // instances and ~30 full-size lines on the default instance.
        release_reset();
        run(31000, 1'b0);
        run(8000, 1'b1);

        // Mid-line reset takes effect before the next clock edge.
        @(posedge clk);
        #2;
        pix_en = 1'b1;
        reset  = 1'b1;
        #1;
        check_reset();
        @(posedge clk);
        #1;
        check_reset();

        release_reset();
        run(2000, 1'b0);
        run(2000, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
